// File: rtl/pipe_loopback_fifo.sv
// pipe_loopback_fifo: block-throttled loopback FIFO between host pipe-in and pipe-out endpoints
module pipe_loopback_fifo #(
   parameter int DEPTH_LOG2  = 10,
   parameter int BLOCK_WORDS = 256
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  pipe_in_write,
   input  logic [15:0]           pipe_in_data,
   output logic                  pipe_in_ready,
   input  logic                  pipe_out_read,
   output logic [15:0]           pipe_out_data,
   output logic                  pipe_out_valid,
   output logic [DEPTH_LOG2:0]   level,
   output logic [15:0]           overflow_count,
   output logic [15:0]           underflow_count
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] DEPTH_W = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0] BLOCK_W = (DEPTH_LOG2+1)'(BLOCK_WORDS);

   logic [15:0] mem [DEPTH];
   logic [DEPTH_LOG2:0] wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next, level_next;
   logic full, empty, wr_en, rd_en;

   assign level       = wr_ptr - rd_ptr;
   assign full        = level == DEPTH_W;
   assign empty       = level == '0;
   assign wr_en       = pipe_in_write & ~full;
   assign rd_en       = pipe_out_read & ~empty;
   assign wr_ptr_next = wr_ptr + (DEPTH_LOG2+1)'(wr_en);
   assign rd_ptr_next = rd_ptr + (DEPTH_LOG2+1)'(rd_en);
   assign level_next  = wr_ptr_next - rd_ptr_next;

   // storage array, kept free of reset so it maps onto block RAM
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[DEPTH_LOG2-1:0]] <= pipe_in_data;
   end

   // pointers, read data, block-granular flags and saturating violation counters
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         pipe_out_data   <= '0;
         pipe_in_ready   <= 1'b0;
         pipe_out_valid  <= 1'b0;
         overflow_count  <= '0;
         underflow_count <= '0;
      end else begin
         wr_ptr         <= wr_ptr_next;
         rd_ptr         <= rd_ptr_next;
         pipe_in_ready  <= (DEPTH_W - level_next) >= BLOCK_W;
         pipe_out_valid <= level_next >= BLOCK_W;
         if (pipe_out_read) pipe_out_data <= empty ? 16'h0000 : mem[rd_ptr[DEPTH_LOG2-1:0]];
         if (pipe_in_write && full && overflow_count != 16'hFFFF) overflow_count <= overflow_count + 16'd1;
         if (pipe_out_read && empty && underflow_count != 16'hFFFF) underflow_count <= underflow_count + 16'd1;
      end
   end
endmodule

// File: tb/tb_pipe_loopback_fifo.sv
// tb_pipe_loopback_fifo: directed self-checking bench for the loopback FIFO
module tb_pipe_loopback_fifo;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic write = 1'b0, read = 1'b0;
   logic [15:0] din = '0;
   logic ready, valid;
   logic [15:0] dout, ovf, unf;
   logic [4:0] lvl;
   logic b_write = 1'b0, b_read = 1'b0;
   logic [15:0] b_din = '0;
   logic b_ready, b_valid;
   logic [15:0] b_dout, b_ovf, b_unf;
   logic [4:0] b_lvl;
   int pass = 0, total = 0;

   always #5 clk = ~clk;

   pipe_loopback_fifo #(.DEPTH_LOG2(4), .BLOCK_WORDS(4)) dut (
      .clk(clk), .reset(reset), .pipe_in_write(write), .pipe_in_data(din), .pipe_in_ready(ready),
      .pipe_out_read(read), .pipe_out_data(dout), .pipe_out_valid(valid), .level(lvl),
      .overflow_count(ovf), .underflow_count(unf));

   pipe_loopback_fifo #(.DEPTH_LOG2(4), .BLOCK_WORDS(16)) dut_b (
      .clk(clk), .reset(reset), .pipe_in_write(b_write), .pipe_in_data(b_din), .pipe_in_ready(b_ready),
      .pipe_out_read(b_read), .pipe_out_data(b_dout), .pipe_out_valid(b_valid), .level(b_lvl),
      .overflow_count(b_ovf), .underflow_count(b_unf));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
      else pass++;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      chk("rst_ready_low", 16'(ready), 16'd0);
      chk("rst_valid_low", 16'(valid), 16'd0);
      reset = 1'b0;
      step();
      chk("idle_level", 16'(lvl), 16'd0);
      chk("idle_ready", 16'(ready), 16'd1);
      chk("idle_valid", 16'(valid), 16'd0);
      chk("idle_ovf", ovf, 16'd0);
      chk("idle_unf", unf, 16'd0);
      chk("idle_dout", dout, 16'd0);
   endtask

   task automatic test_basic();
      for (int i = 1; i <= 4; i++) begin
         write = 1'b1;
         din = 16'(i * 16'h1111);
         step();
         chk("basic_wr_valid", 16'(valid), 16'(i == 4));
      end
      write = 1'b0;
      chk("basic_level4", 16'(lvl), 16'd4);
      for (int i = 1; i <= 4; i++) begin
         read = 1'b1;
         step();
         chk("basic_rd_data", dout, 16'(i * 16'h1111));
      end
      read = 1'b0;
      chk("basic_valid_off", 16'(valid), 16'd0);
      chk("basic_level0", 16'(lvl), 16'd0);
      step();
      chk("basic_data_hold", dout, 16'h4444);
   endtask

   task automatic test_fill();
      for (int i = 0; i < 16; i++) begin
         write = 1'b1;
         din = 16'hA000 + 16'(i);
         step();
         if (i == 11) chk("fill_ready_at12", 16'(ready), 16'd1);
         if (i == 12) chk("fill_ready_at13", 16'(ready), 16'd0);
      end
      chk("fill_level16", 16'(lvl), 16'd16);
      chk("fill_valid", 16'(valid), 16'd1);
      din = 16'hDEAD;
      step();
      write = 1'b0;
      chk("fill_ovf1", ovf, 16'd1);
      chk("fill_level_after_ovf", 16'(lvl), 16'd16);
      for (int i = 0; i < 16; i++) begin
         read = 1'b1;
         step();
         chk("fill_rd_data", dout, 16'hA000 + 16'(i));
      end
      read = 1'b0;
      chk("fill_drained", 16'(lvl), 16'd0);
      chk("fill_ready_back", 16'(ready), 16'd1);
   endtask

   task automatic test_underflow();
      for (int i = 0; i < 3; i++) begin
         read = 1'b1;
         step();
      end
      read = 1'b0;
      chk("unf_count3", unf, 16'd3);
      chk("unf_dout0", dout, 16'h0000);
      chk("unf_level0", 16'(lvl), 16'd0);
      chk("unf_ovf_kept", ovf, 16'd1);
   endtask

   task automatic test_simul();
      for (int i = 0; i < 5; i++) begin
         write = 1'b1;
         din = 16'h0100 + 16'(i);
         step();
      end
      for (int i = 0; i < 20; i++) begin
         write = 1'b1;
         read = 1'b1;
         din = 16'h0105 + 16'(i);
         step();
         chk("simul_level5", 16'(lvl), 16'd5);
         chk("simul_data", dout, 16'h0100 + 16'(i));
      end
      write = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("simul_drain", dout, 16'h0114 + 16'(i));
      end
      read = 1'b0;
      chk("simul_empty", 16'(lvl), 16'd0);
      chk("simul_no_ovf", ovf, 16'd1);
      chk("simul_no_unf", unf, 16'd3);
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 10; i++) begin
         write = 1'b1;
         din = 16'hB000 + 16'(i);
         step();
      end
      reset = 1'b1;
      step();
      chk("mid_rst_ready", 16'(ready), 16'd0);
      chk("mid_rst_valid", 16'(valid), 16'd0);
      write = 1'b0;
      reset = 1'b0;
      step();
      chk("mid_level0", 16'(lvl), 16'd0);
      chk("mid_ovf0", ovf, 16'd0);
      chk("mid_unf0", unf, 16'd0);
      chk("mid_ready", 16'(ready), 16'd1);
      chk("mid_valid", 16'(valid), 16'd0);
      read = 1'b1;
      step();
      read = 1'b0;
      chk("mid_rd_unf", unf, 16'd1);
      chk("mid_rd_dout", dout, 16'h0000);
   endtask

   task automatic test_block16();
      chk("b16_ready_empty", 16'(b_ready), 16'd1);
      for (int i = 0; i < 16; i++) begin
         b_write = 1'b1;
         b_din = 16'hC000 + 16'(i);
         step();
         chk("b16_ready_fill", 16'(b_ready), 16'd0);
         chk("b16_valid_fill", 16'(b_valid), 16'(i == 15));
      end
      b_write = 1'b0;
      for (int i = 0; i < 16; i++) begin
         b_read = 1'b1;
         step();
         chk("b16_data", b_dout, 16'hC000 + 16'(i));
         chk("b16_valid_drain", 16'(b_valid), 16'd0);
         chk("b16_ready_drain", 16'(b_ready), 16'(i == 15));
      end
      b_read = 1'b0;
      chk("b16_level0", 16'(b_lvl), 16'd0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_fill();
      test_underflow();
      test_simul();
      test_reset_mid();
      test_block16();
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule

// File: doc/pipe_loopback_fifo.md
Name: pipe_loopback_fifo

Overview:
Buffers 16-bit words written by the host through the block-throttled pipe-in endpoint and returns them through the block-throttled pipe-out endpoint, for host-side loopback integrity and throughput tests. It is the FIFO end between the two endpoints: it drives the write-side and read-side ready flags on block granularity and counts protocol violations (writes when full, reads when empty). It runs entirely in the host-interface clock domain.

Parameters:
DEPTH_LOG2, 10, log2 of FIFO depth in words (depth = 2^DEPTH_LOG2)
BLOCK_WORDS, 256, pipe block size in 16-bit words; legal range 1..2^DEPTH_LOG2

Ports:
clk  input  1  host-interface clock; all logic on rising edge
reset  input  1  synchronous, active-high; clears FIFO and counters
pipe_in_write  input  1  write strobe from the pipe-in endpoint
pipe_in_data  input  16  write data, valid when pipe_in_write=1
pipe_in_ready  output  1  at least BLOCK_WORDS free words are available
pipe_out_read  input  1  read strobe from the pipe-out endpoint
pipe_out_data  output  16  read data, registered
pipe_out_valid  output  1  at least BLOCK_WORDS stored words are available (endpoint ready)
level  output  DEPTH_LOG2+1  current stored word count, 0..2^DEPTH_LOG2
overflow_count  output  16  writes dropped because the FIFO was full; saturates at 16'hFFFF
underflow_count  output  16  reads made while the FIFO was empty; saturates at 16'hFFFF

Behaviour:
- Storage: 2^DEPTH_LOG2 x 16 RAM. wr_ptr and rd_ptr are DEPTH_LOG2+1 bits and wrap naturally. level = wr_ptr - rd_ptr (modulo).
- full = (level == 2^DEPTH_LOG2). empty = (level == 0).
- Write, cycle N: if pipe_in_write=1 and full=0, store pipe_in_data at wr_ptr and increment wr_ptr at edge N. If full=1, drop the word, leave wr_ptr unchanged, and increment overflow_count (saturating).
- Read, cycle N: if pipe_out_read=1 and empty=0, register mem[rd_ptr] into pipe_out_data at edge N and increment rd_ptr. The data is stable from cycle N+1 until the next accepted read. This one-cycle read latency matches the pipe-out endpoint.
- Read when empty: pipe_out_data <= 16'h0000, rd_ptr unchanged, underflow_count increments (saturating).
- Simultaneous read and write:
  - Both complete in the same cycle; level is unchanged.
  - If empty, the read still underflows. There is no write-to-read bypass.
  - If full, the write still overflows, even though the read frees a slot in the same cycle.
- Flags are registered from next-state level (the level after this edge's updates):
  - pipe_in_ready <= (2^DEPTH_LOG2 - level_next) >= BLOCK_WORDS
  - pipe_out_valid <= level_next >= BLOCK_WORDS
  - Both flags reflect a write or read one cycle after it.
- level output is the current registered level (not next-state).
- Reset (synchronous; applies at any time, including mid-block):
  - Pointers cleared, so contents are discarded.
  - pipe_out_data=0, overflow_count=0, underflow_count=0, level=0.
  - pipe_in_ready=0 and pipe_out_valid=0 while reset is high.
  - First edge after reset deasserts: pipe_in_ready=1 (empty FIFO always has room for a block), pipe_out_valid=0.
- The block does not check the endpoint's block boundaries. Strobes beyond a block are handled per word by the rules above.

Test Plan:
(Bench uses DEPTH_LOG2=4 (16 words), BLOCK_WORDS=4 unless stated.)
- Reset then idle: required state after 1 cycle is level=0, pipe_in_ready=1, pipe_out_valid=0, both counters 0.
- Write 4 words 16'h1111..16'h4444, then read 4 → pipe_out_valid=1 one cycle after the 4th write. Data 1111, 2222, 3333, 4444 appears one cycle after each read. pipe_out_valid=0 after the 4th read.
- Write 13 words → pipe_in_ready drops to 0 one cycle after the 13th write (free=3 < 4). Write 3 more → level=16. A 17th write → overflow_count=1 and the data is dropped. Read 16 → the original sequence is returned intact.
- Read on an empty FIFO 3 times → underflow_count=3, pipe_out_data=0000, level stays 0.
- Simultaneous read+write with level=5 for 20 cycles on an incrementing pattern → level stays 5, output order preserved, pointers wrap past 16 without error.
- Fill 10 words, assert reset for 1 cycle mid-stream → level=0, counters 0, and the next read underflows. DEPTH_LOG2=4, BLOCK_WORDS=16 → pipe_in_ready=1 only when empty, pipe_out_valid=1 only when full.
